// File: rtl/update_pattern_grid_pkg.sv
// Shared types and constants for the 5x5 display pattern grid.
// Rows are COLS bits wide; a grid is ROWS rows with the newest row at the top index.
package pattern_pkg;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int CNT_W = 3;
  localparam int RES_W = 12;

  localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(ROWS);

  typedef logic [COLS-1:0] row_t;
  typedef row_t [ROWS-1:0] grid_t;

  typedef enum logic {
    DOT = 1'b0,
    BAR = 1'b1
  } enc_mode_e;

  // Saturating increment used by the row counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    sat_inc = (value >= limit) ? limit : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/update_pattern_grid_if.sv
// Bundle between the result datapath (master) and the pattern grid (slave).
// The display driver reads pattern/full/row_count straight off this bundle.
interface update_pattern_grid_if;
  import pattern_pkg::*;

  logic                  set;
  logic [RES_W-1:0]      result;
  logic                  data;
  grid_t                 pattern;
  logic                  full;
  logic [CNT_W-1:0]      row_count;

  modport master (
    output set,
    output result,
    output data,
    input  pattern,
    input  full,
    input  row_count
  );

  modport slave (
    input  set,
    input  result,
    input  data,
    output pattern,
    output full,
    output row_count
  );

endinterface

// File: rtl/update_pattern_grid_row_enc.sv
// Combinational row encoder: turns a 12-bit result into one 5-bit display row,
// either a single dot (one-hot) or a bar (thermometer).
module pattern_row_enc
  import pattern_pkg::*;
(
  input  logic [RES_W-1:0] result,
  input  logic             data,
  output row_t             row
);

  enc_mode_e mode;

  assign mode = enc_mode_e'(data);

  // Full-width compares, so large results never alias onto small ones.
  always_comb begin
    row = '0;
    for (int i = 0; i < COLS; i++) begin
      if (mode == BAR) begin
        row[i] = (result > RES_W'(i));
      end else begin
        row[i] = (result == RES_W'(i + 1));
      end
    end
  end

endmodule

// File: rtl/update_pattern_grid.sv
// Pattern grid top: shifts an encoded row in at the top on every set cycle
// and keeps a saturating count of rows written since reset.
module update_pattern_grid
  import pattern_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  update_pattern_grid_if.slave bus
);

  grid_t            grid_q, grid_d;
  logic [CNT_W-1:0] row_count_q, row_count_d;
  logic             full_q, full_d;
  row_t             new_row;

  pattern_row_enc u_row_enc (
    .result (bus.result),
    .data   (bus.data),
    .row    (new_row)
  );

  // Newest row enters at index ROWS-1; the row at index 0 falls off.
  always_comb begin
    grid_d      = grid_q;
    row_count_d = row_count_q;
    if (bus.set) begin
      grid_d      = {new_row, grid_q[ROWS-1:1]};
      row_count_d = sat_inc(row_count_q, MAX_ROWS);
    end
    full_d = (row_count_d == MAX_ROWS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid_q      <= '0;
      row_count_q <= '0;
      full_q      <= 1'b0;
    end else begin
      grid_q      <= grid_d;
      row_count_q <= row_count_d;
      full_q      <= full_d;
    end
  end

  assign bus.pattern   = grid_q;
  assign bus.full      = full_q;
  assign bus.row_count = row_count_q;

endmodule

// File: tb/tb_update_pattern_grid.sv
// Self-checking bench: a row-list reference model is compared against the grid
// every cycle, with directed literal checks and a randomized phase.
module tb_update_pattern_grid;
  import pattern_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   check_en;

  update_pattern_grid_if bus_if ();

  update_pattern_grid dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: list of rows, index 0 oldest, plus a plain integer count.
  logic [4:0] m_rows [5];
  int         m_count;

  function automatic logic [4:0] exp_row(input int unsigned r, input bit bar);
    int unsigned m;
    if (bar) begin
      m = (r > 5) ? 5 : r;
      return 5'((1 << m) - 1);
    end
    if (r >= 1 && r <= 5) return 5'(1 << (r - 1));
    return 5'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) m_rows[i] = 5'd0;
      m_count = 0;
    end else if (bus_if.set) begin
      for (int i = 0; i < 4; i++) m_rows[i] = m_rows[i + 1];
      m_rows[4] = exp_row(int'(bus_if.result), bus_if.data);
      if (m_count < 5) m_count = m_count + 1;
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the clock edge.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus_if.pattern[i] !== m_rows[i]) begin
          errors++;
          $display("[TB] FAIL model_row%0d got %b want %b at %0t", i, bus_if.pattern[i], m_rows[i], $time);
        end
      end
      checks++;
      if (bus_if.row_count !== 3'(m_count)) begin
        errors++;
        $display("[TB] FAIL model_count got %0d want %0d at %0t", bus_if.row_count, m_count, $time);
      end
      checks++;
      if (bus_if.full !== (m_count == 5)) begin
        errors++;
        $display("[TB] FAIL model_full got %b want %b at %0t", bus_if.full, (m_count == 5), $time);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic s, input logic [11:0] r, input logic d);
    @(negedge clk);
    reset         = rst;
    bus_if.set    = s;
    bus_if.result = r;
    bus_if.data   = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic pulse(input logic [11:0] r, input logic d);
    applyStimulus(1'b0, 1'b1, r, d);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    reset         = 1'b1;
    bus_if.set    = 1'b1;
    bus_if.result = 12'd3;
    bus_if.data   = 1'b0;

    // Reset held two cycles with set high.
    applyStimulus(1'b1, 1'b1, 12'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 12'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0);
    check_en = 1'b1;
    checkOutput("reset_pattern", 32'(bus_if.pattern), 32'd0);
    checkOutput("reset_count", 32'(bus_if.row_count), 32'd0);
    checkOutput("reset_full", 32'(bus_if.full), 32'd0);

    // Dot sequence 2,1,4,0,0.
    pulse(12'd2, 1'b0);
    pulse(12'd1, 1'b0);
    pulse(12'd4, 1'b0);
    pulse(12'd0, 1'b0);
    pulse(12'd0, 1'b0);
    checkOutput("dot_row0", 32'(bus_if.pattern[0]), 32'b00010);
    checkOutput("dot_row1", 32'(bus_if.pattern[1]), 32'b00001);
    checkOutput("dot_row2", 32'(bus_if.pattern[2]), 32'b01000);
    checkOutput("dot_row3", 32'(bus_if.pattern[3]), 32'd0);
    checkOutput("dot_row4", 32'(bus_if.pattern[4]), 32'd0);
    checkOutput("dot_full", 32'(bus_if.full), 32'd1);

    // Held set: one row then two blank rows.
    applyStimulus(1'b1, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 12'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0);
    checkOutput("held_row2", 32'(bus_if.pattern[2]), 32'b00100);
    checkOutput("held_row4", 32'(bus_if.pattern[4]), 32'd0);
    checkOutput("held_count", 32'(bus_if.row_count), 32'd3);

    // Bar mode.
    pulse(12'd3, 1'b1);
    checkOutput("bar_3", 32'(bus_if.pattern[4]), 32'b00111);
    pulse(12'hFFF, 1'b1);
    checkOutput("bar_fff", 32'(bus_if.pattern[4]), 32'b11111);
    checkOutput("bar_shift", 32'(bus_if.pattern[3]), 32'b00111);

    // Out-of-range dot values still shift.
    pulse(12'd6, 1'b0);
    checkOutput("dot_6", 32'(bus_if.pattern[4]), 32'd0);
    checkOutput("dot_6_shift", 32'(bus_if.pattern[3]), 32'b11111);
    pulse(12'h800, 1'b0);
    checkOutput("dot_800", 32'(bus_if.pattern[4]), 32'd0);
    checkOutput("dot_800_shift", 32'(bus_if.pattern[2]), 32'b11111);

    // Saturation, then reset together with set.
    applyStimulus(1'b1, 1'b0, 12'd0, 1'b0);
    for (int i = 0; i < 7; i++) pulse(12'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    checkOutput("sat_count", 32'(bus_if.row_count), 32'd5);
    checkOutput("sat_full", 32'(bus_if.full), 32'd1);
    applyStimulus(1'b1, 1'b1, 12'd5, 1'b1);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0);
    checkOutput("rst_set_pattern", 32'(bus_if.pattern), 32'd0);
    checkOutput("rst_set_count", 32'(bus_if.row_count), 32'd0);
    checkOutput("rst_set_full", 32'(bus_if.full), 32'd0);

    // Randomized phase, mostly small results to exercise every encoding.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] r;
      r = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0);
    @(negedge clk);
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
